matrix_stream_loader: RTL and testbench

Parameterised byte-stream front end for the matrix multiplier. Accepts a header of four dimension beats followed by the row-major elements of matrices A and B over a valid/ready stream. Stores both matrices in fixed MAX_DIM×MAX_DIM slot arrays and checks the dimensions. It then presents the operands to the multiplier with a start/done handshake, supporting any shape up to MAX_DIM×MAX_DIM.

---
 rtl/matrix_stream_loader.sv | 240 ++++++++++++++++++++++++
 tb/tb_matrix_stream_loader.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader
// Byte-stream front end for the matrix multiplier. A transaction is four header
// beats (rows_a, cols_a, rows_b, cols_b) followed by the row-major elements of A
// then B. Elements land in fixed MAX_DIM x MAX_DIM slot arrays (slot r*MAX_DIM+c)
// and are handed to the multiplier with a start/done handshake.
//
// Ports:
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   soft_clr            synchronous abort to IDLE, highest priority
//   in_data/in_hdr      stream beat and its header/element tag
//   in_valid/in_ready   stream handshake; in_ready depends on state only
//   rows_a..cols_b      latched dimensions
//   mat_a, mat_b        flat operand storage, DATA_W bits per slot
//   mat_valid           operands complete (READY)
//   mult_start/done     multiplier handshake
//   busy                multiplier owns the operands (BUSY)
//   err/err_code        sticky error: 01 range, 10 inner mismatch, 11 protocol
module matrix_stream_loader #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned MAX_DIM = 4,
  parameter int unsigned DIM_W   = $clog2(MAX_DIM + 1)
) (
  input  logic                               CLK,
  input  logic                               RST_N,
  input  logic                               soft_clr,
  input  logic [DATA_W-1:0]                  in_data,
  input  logic                               in_hdr,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic [DIM_W-1:0]                   rows_a,
  output logic [DIM_W-1:0]                   cols_a,
  output logic [DIM_W-1:0]                   rows_b,
  output logic [DIM_W-1:0]                   cols_b,
  output logic [MAX_DIM*MAX_DIM*DATA_W-1:0]  mat_a,
  output logic [MAX_DIM*MAX_DIM*DATA_W-1:0]  mat_b,
  output logic                               mat_valid,
  input  logic                               mult_start,
  input  logic                               mult_done,
  output logic                               busy,
  output logic                               err,
  output logic [1:0]                         err_code
);

  localparam int unsigned NSlot  = MAX_DIM * MAX_DIM;
  localparam int unsigned SlotW  = $clog2(NSlot);
  localparam int unsigned CntW   = 2 * DIM_W;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StHdr   = 3'd1;
  localparam logic [2:0] StLoadA = 3'd2;
  localparam logic [2:0] StLoadB = 3'd3;
  localparam logic [2:0] StReady = 3'd4;
  localparam logic [2:0] StBusy  = 3'd5;
  localparam logic [2:0] StError = 3'd6;

  localparam logic [1:0] ErrRange = 2'b01;
  localparam logic [1:0] ErrInner = 2'b10;
  localparam logic [1:0] ErrProto = 2'b11;

  localparam logic [DATA_W-1:0] MaxDimBeat = DATA_W'(MAX_DIM);

  logic [2:0]                          state_q, state_d;
  logic [1:0]                          hdr_cnt_q, hdr_cnt_d;
  logic [DIM_W-1:0]                    row_q, row_d, col_q, col_d;
  logic [CntW-1:0]                     cnt_q, cnt_d;
  logic [DIM_W-1:0]                    rows_a_q, rows_a_d, cols_a_q, cols_a_d;
  logic [DIM_W-1:0]                    rows_b_q, rows_b_d, cols_b_q, cols_b_d;
  logic                                hdr_bad_q, hdr_bad_d;
  logic [1:0]                          err_code_q, err_code_d;
  logic [NSlot-1:0][DATA_W-1:0]        mat_a_q, mat_a_d, mat_b_q, mat_b_d;
  logic                                in_ready_q, in_ready_d;

  logic                                xfer;
  logic                                beat_bad;
  logic [SlotW-1:0]                    slot;
  logic [DIM_W-1:0]                    cols_cur, rows_cur;
  logic [CntW-1:0]                     total_cur, cnt_next;

  assign xfer     = in_valid & in_ready_q;
  // Range check on the full beat so an oversized value cannot alias into range.
  assign beat_bad = (in_data == '0) || (in_data > MaxDimBeat);
  assign slot     = SlotW'(row_q) * SlotW'(MAX_DIM) + SlotW'(col_q);
  assign rows_cur = (state_q == StLoadB) ? rows_b_q : rows_a_q;
  assign cols_cur = (state_q == StLoadB) ? cols_b_q : cols_a_q;
  assign total_cur = CntW'(rows_cur) * CntW'(cols_cur);
  assign cnt_next  = cnt_q + CntW'(1);

  always_comb begin
    state_d    = state_q;
    hdr_cnt_d  = hdr_cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    rows_a_d   = rows_a_q;
    cols_a_d   = cols_a_q;
    rows_b_d   = rows_b_q;
    cols_b_d   = cols_b_q;
    hdr_bad_d  = hdr_bad_q;
    err_code_d = err_code_q;
    mat_a_d    = mat_a_q;
    mat_b_d    = mat_b_q;

    if (soft_clr) begin
      state_d    = StIdle;
      hdr_cnt_d  = '0;
      row_d      = '0;
      col_d      = '0;
      cnt_d      = '0;
      hdr_bad_d  = 1'b0;
      err_code_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (xfer) begin
            if (in_hdr) begin
              rows_a_d  = in_data[DIM_W-1:0];
              hdr_bad_d = beat_bad;
              hdr_cnt_d = 2'd1;
              state_d   = StHdr;
            end else begin
              state_d    = StError;
              err_code_d = ErrProto;
            end
          end
        end
        StHdr: begin
          if (xfer) begin
            if (!in_hdr) begin
              state_d    = StError;
              err_code_d = ErrProto;
            end else begin
              hdr_bad_d = hdr_bad_q | beat_bad;
              hdr_cnt_d = hdr_cnt_q + 2'd1;
              case (hdr_cnt_q)
                2'd1:    cols_a_d = in_data[DIM_W-1:0];
                2'd2:    rows_b_d = in_data[DIM_W-1:0];
                default: cols_b_d = in_data[DIM_W-1:0];
              endcase
              if (hdr_cnt_q == 2'd3) begin
                hdr_cnt_d = '0;
                if (hdr_bad_q | beat_bad) begin
                  state_d    = StError;
                  err_code_d = ErrRange;
                end else if (cols_a_q != rows_b_q) begin
                  state_d    = StError;
                  err_code_d = ErrInner;
                end else begin
                  state_d = StLoadA;
                  mat_a_d = '0;
                  mat_b_d = '0;
                  row_d   = '0;
                  col_d   = '0;
                  cnt_d   = '0;
                end
              end
            end
          end
        end
        StLoadA, StLoadB: begin
          if (xfer) begin
            if (in_hdr) begin
              state_d    = StError;
              err_code_d = ErrProto;
            end else begin
              if (state_q == StLoadA) mat_a_d[slot] = in_data;
              else                    mat_b_d[slot] = in_data;
              if (cnt_next == total_cur) begin
                state_d = (state_q == StLoadA) ? StLoadB : StReady;
                row_d   = '0;
                col_d   = '0;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_next;
                if (col_q == cols_cur - DIM_W'(1)) begin
                  col_d = '0;
                  row_d = row_q + DIM_W'(1);
                end else begin
                  col_d = col_q + DIM_W'(1);
                end
              end
            end
          end
        end
        StReady: if (mult_start) state_d = StBusy;
        StBusy:  if (mult_done)  state_d = StIdle;
        StError: ;
        default: state_d = StIdle;
      endcase
    end

    in_ready_d = (state_d != StReady) && (state_d != StBusy);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      hdr_cnt_q  <= '0;
      row_q      <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      rows_a_q   <= '0;
      cols_a_q   <= '0;
      rows_b_q   <= '0;
      cols_b_q   <= '0;
      hdr_bad_q  <= 1'b0;
      err_code_q <= '0;
      mat_a_q    <= '0;
      mat_b_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      hdr_cnt_q  <= hdr_cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      rows_a_q   <= rows_a_d;
      cols_a_q   <= cols_a_d;
      rows_b_q   <= rows_b_d;
      cols_b_q   <= cols_b_d;
      hdr_bad_q  <= hdr_bad_d;
      err_code_q <= err_code_d;
      mat_a_q    <= mat_a_d;
      mat_b_q    <= mat_b_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign rows_a    = rows_a_q;
  assign cols_a    = cols_a_q;
  assign rows_b    = rows_b_q;
  assign cols_b    = cols_b_q;
  assign mat_a     = mat_a_q;
  assign mat_b     = mat_b_q;
  assign mat_valid = (state_q == StReady);
  assign busy      = (state_q == StBusy);
  assign err       = (state_q == StError);
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_matrix_stream_loader.sv
// Testbench for matrix_stream_loader: directed transactions, a queue-based
// transaction model checked every cycle, plus hand-computed literal checks.
module tb_matrix_stream_loader;

  localparam int DATA_W  = 8;
  localparam int MAX_DIM = 4;
  localparam int DIM_W   = $clog2(MAX_DIM + 1);
  localparam int NS      = MAX_DIM * MAX_DIM;
  localparam int MW      = NS * DATA_W;
  localparam int DMASK   = (1 << DIM_W) - 1;

  logic              CLK, RST_N, soft_clr, in_hdr, in_valid, in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DIM_W-1:0]  rows_a, cols_a, rows_b, cols_b;
  logic [MW-1:0]     mat_a, mat_b;
  logic              mat_valid, mult_start, mult_done, busy, err;
  logic [1:0]        err_code;

  matrix_stream_loader #(.DATA_W(DATA_W), .MAX_DIM(MAX_DIM)) dut (
    .CLK(CLK), .RST_N(RST_N), .soft_clr(soft_clr),
    .in_data(in_data), .in_hdr(in_hdr), .in_valid(in_valid), .in_ready(in_ready),
    .rows_a(rows_a), .cols_a(cols_a), .rows_b(rows_b), .cols_b(cols_b),
    .mat_a(mat_a), .mat_b(mat_b), .mat_valid(mat_valid),
    .mult_start(mult_start), .mult_done(mult_done),
    .busy(busy), .err(err), .err_code(err_code)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sa(input int s);
    return int'(mat_a[s*DATA_W +: DATA_W]);
  endfunction
  function automatic int sb(input int s);
    return int'(mat_b[s*DATA_W +: DATA_W]);
  endfunction

  // Transaction model: mode 0 = accepting a transaction, 1 = operands ready,
  // 2 = multiplier busy, 3 = error. Header/element progress is the queue sizes.
  int m_mode, m_code;
  int hq[$];
  int eq[$];
  int m_dim[4];
  int ma[NS];
  int mb[NS];

  function automatic void model_reset();
    m_mode = 0; m_code = 0;
    hq.delete(); eq.delete();
    for (int i = 0; i < 4; i++) m_dim[i] = 0;
    for (int s = 0; s < NS; s++) begin ma[s] = 0; mb[s] = 0; end
  endfunction

  function automatic bit m_ready();
    return (m_mode == 0) || (m_mode == 3);
  endfunction

  function automatic void model_step();
    int d, k, na, nb;
    bit rng;
    d = int'(in_data);
    if (soft_clr) begin
      m_mode = 0; m_code = 0; hq.delete(); eq.delete();
      return;
    end
    case (m_mode)
      0: if (in_valid) begin
        if (hq.size() < 4) begin
          if (!in_hdr) begin m_mode = 3; m_code = 3; end
          else begin
            m_dim[hq.size()] = d;
            hq.push_back(d);
            if (hq.size() == 4) begin
              rng = 1'b0;
              for (int i = 0; i < 4; i++) if (hq[i] == 0 || hq[i] > MAX_DIM) rng = 1'b1;
              if (rng) begin m_mode = 3; m_code = 1; end
              else if (hq[1] != hq[2]) begin m_mode = 3; m_code = 2; end
              else for (int s = 0; s < NS; s++) begin ma[s] = 0; mb[s] = 0; end
            end
          end
        end else if (in_hdr) begin
          m_mode = 3; m_code = 3;
        end else begin
          na = hq[0] * hq[1];
          nb = hq[2] * hq[3];
          k  = eq.size();
          if (k < na) ma[(k / hq[1]) * MAX_DIM + k % hq[1]] = d;
          else        mb[((k - na) / hq[3]) * MAX_DIM + (k - na) % hq[3]] = d;
          eq.push_back(d);
          if (eq.size() == na + nb) m_mode = 1;
        end
      end
      1: if (mult_start) m_mode = 2;
      2: if (mult_done) begin m_mode = 0; hq.delete(); eq.delete(); end
      default: ;
    endcase
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge CLK or negedge RST_N);
      if (!RST_N) model_reset();
      else        model_step();
    end
  end

  // Per-cycle compare against the model.
  initial begin
    logic [MW-1:0] ea, eb;
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        for (int s = 0; s < NS; s++) begin
          ea[s*DATA_W +: DATA_W] = DATA_W'(ma[s]);
          eb[s*DATA_W +: DATA_W] = DATA_W'(mb[s]);
        end
        chk("in_ready", int'(in_ready), int'(m_ready()));
        chk("mat_valid", int'(mat_valid), int'(m_mode == 1));
        chk("busy", int'(busy), int'(m_mode == 2));
        chk("err", int'(err), int'(m_mode == 3));
        chk("err_code", int'(err_code), m_code);
        chk("rows_a", int'(rows_a), m_dim[0] & DMASK);
        chk("cols_a", int'(cols_a), m_dim[1] & DMASK);
        chk("rows_b", int'(rows_b), m_dim[2] & DMASK);
        chk("cols_b", int'(cols_b), m_dim[3] & DMASK);
        chkw("mat_a", mat_a, ea);
        chkw("mat_b", mat_b, eb);
      end
    end
  end

  task automatic beat(input bit h, input int d);
    int n;
    in_valid = 1'b1; in_hdr = h; in_data = DATA_W'(d);
    n = 0;
    while (!in_ready && n < 50) begin @(posedge CLK); #1; n++; end
    if (n >= 50) begin
      bad++; total++;
      $display("FAIL beat_timeout: in_ready stayed %0d, required 1", in_ready);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0; in_hdr = 1'($urandom); in_data = DATA_W'($urandom);
  endtask

  task automatic idle(input int k);
    in_valid = 1'b0;
    repeat (k) begin @(posedge CLK); #1; end
  endtask

  task automatic header(input int a, input int b, input int c, input int d);
    beat(1'b1, a); beat(1'b1, b); beat(1'b1, c); beat(1'b1, d);
  endtask

  task automatic pulse_start();
    mult_start = 1'b1; @(posedge CLK); #1; mult_start = 1'b0;
  endtask
  task automatic pulse_done();
    mult_done = 1'b1; @(posedge CLK); #1; mult_done = 1'b0;
  endtask
  task automatic pulse_clr();
    soft_clr = 1'b1; @(posedge CLK); #1; soft_clr = 1'b0;
  endtask

  initial begin
    RST_N = 1'b1; soft_clr = 1'b0; in_data = '0; in_hdr = 1'b0; in_valid = 1'b0;
    mult_start = 1'b0; mult_done = 1'b0;
    #1 RST_N = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_mat_valid", int'(mat_valid), 0);
    chk("rst_err_code", int'(err_code), 0);
    chkw("rst_mat_a", mat_a, '0);

    // mult_start outside READY is ignored
    pulse_start();
    chk("idle_start_busy", int'(busy), 0);

    // 2x2 by 2x2, back-to-back: mat_valid on cycle 13
    header(2, 2, 2, 2);
    for (int i = 1; i <= 7; i++) beat(1'b0, i);
    chk("t1_valid_c12", int'(mat_valid), 0);
    beat(1'b0, 8);
    chk("t1_valid_c13", int'(mat_valid), 1);
    chk("t1_in_ready", int'(in_ready), 0);
    chk("t1_a0", sa(0), 1); chk("t1_a1", sa(1), 2);
    chk("t1_a4", sa(4), 3); chk("t1_a5", sa(5), 4);
    chk("t1_b5", sb(5), 8); chk("t1_a2", sa(2), 0);
    pulse_start();
    chk("t1_busy", int'(busy), 1);
    chk("t1_valid_off", int'(mat_valid), 0);
    pulse_done();
    chk("t1_idle_ready", int'(in_ready), 1);

    // 3x2 by 2x4 with random gaps
    header(3, 2, 2, 4);
    for (int i = 10; i <= 15; i++) begin idle($urandom_range(0, 2)); beat(1'b0, i); end
    for (int i = 20; i <= 27; i++) begin idle($urandom_range(0, 2)); beat(1'b0, i); end
    chk("t2_a8", sa(8), 14); chk("t2_a9", sa(9), 15);
    chk("t2_b3", sb(3), 23); chk("t2_b7", sb(7), 27);
    chk("t2_valid", int'(mat_valid), 1);
    pulse_start(); pulse_done();

    // Range error, beats consumed, soft_clr recovers
    header(5, 2, 2, 2);
    chk("t3_err", int'(err), 1);
    chk("t3_code", int'(err_code), 1);
    beat(1'b0, 9); beat(1'b1, 3); beat(1'b0, 4);
    chk("t3_err_held", int'(err), 1);
    pulse_clr();
    chk("t3_clr_err", int'(err), 0);

    // Inner dimension mismatch
    header(2, 3, 2, 2);
    chk("t4_code", int'(err_code), 2);
    pulse_clr();

    // Header beat during LOAD_A: protocol error, no write
    header(2, 2, 2, 2);
    beat(1'b0, 7);
    beat(1'b1, 99);
    chk("t5_code", int'(err_code), 3);
    chk("t5_a0", sa(0), 7);
    chk("t5_a1", sa(1), 0);
    pulse_clr();

    // soft_clr coincident with the 3rd B element, then a clean reload
    header(2, 2, 2, 2);
    for (int i = 1; i <= 6; i++) beat(1'b0, i);
    in_valid = 1'b1; in_hdr = 1'b0; in_data = 8'd77; soft_clr = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0; soft_clr = 1'b0;
    chk("t6_clr_valid", int'(mat_valid), 0);
    chk("t6_b4_kept", sb(4), 0);
    header(2, 2, 2, 2);
    for (int i = 31; i <= 38; i++) beat(1'b0, i);
    chk("t6_a0", sa(0), 31); chk("t6_b4", sb(4), 37);
    chk("t6_valid", int'(mat_valid), 1);
    pulse_start(); pulse_done();

    // Asynchronous reset between edges during LOAD_B
    header(2, 2, 2, 2);
    for (int i = 1; i <= 5; i++) beat(1'b0, i);
    #2 RST_N = 1'b0;
    #1;
    chk("t7_rows_a", int'(rows_a), 0);
    chkw("t7_mat_a", mat_a, '0);
    chk("t7_in_ready", int'(in_ready), 1);
    @(posedge CLK); #1 RST_N = 1'b1;
    pulse_start();
    chk("t7_start_ignored", int'(busy), 0);

    idle(3);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
